// File: rtl/projectile_pkg.sv
// Shared types, constants and helpers for the projectile launcher and
// related slot allocators.
package projectile_pkg;

  typedef enum logic [0:0] {
    ALLOC_LOWEST = 1'b0,
    ALLOC_RR     = 1'b1
  } alloc_mode_t;

  localparam logic [7:0] FIRE_KEY_DEFAULT = 8'h29;

  // Number of set bits in a vector of up to 16 slots.
  function automatic logic [4:0] popcount(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/projectile_launcher_slot_picker.sv
// Combinational slot allocator: picks the lowest set request, or the first
// set request at or after a start pointer with wrap-around.
module slot_picker
  import projectile_pkg::*;
#(
  parameter int          NUM_SLOTS  = 5,
  parameter alloc_mode_t ALLOC_MODE = ALLOC_LOWEST,
  localparam int         IW         = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [IW-1:0]        start,
  output logic                 valid,
  output logic [IW-1:0]        index
);

  logic [IW:0] pos_s;
  logic        hit_s;

  // Scan in priority order; the first hit is kept.
  always_comb begin
    valid = 1'b0;
    index = {IW{1'b0}};
    pos_s = {(IW+1){1'b0}};
    hit_s = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pos_s = (ALLOC_MODE == ALLOC_RR) ? ({1'b0, start} + (IW+1)'(i)) : (IW+1)'(i);
      pos_s = (pos_s >= (IW+1)'(NUM_SLOTS)) ? (pos_s - (IW+1)'(NUM_SLOTS)) : pos_s;
      hit_s = !valid && req[pos_s[IW-1:0]];
      index = hit_s ? pos_s[IW-1:0] : index;
      valid = valid | hit_s;
    end
  end

endmodule

// File: rtl/projectile_launcher.sv
// Allocates a keyboard launch request to one of NUM_SLOTS projectile movers,
// with per-press re-arm, frame cooldown and a live-projectile limit.
module projectile_launcher
  import projectile_pkg::*;
#(
  parameter int          NUM_SLOTS       = 5,
  parameter logic [7:0]  FIRE_KEY        = FIRE_KEY_DEFAULT,
  parameter int          COOLDOWN_FRAMES = 8,
  parameter alloc_mode_t ALLOC_MODE      = ALLOC_LOWEST,
  parameter int          MAX_LIVE        = NUM_SLOTS,
  localparam int         IW              = $clog2(NUM_SLOTS)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk_edge,
  input  logic [7:0]           keycode,
  input  logic                 press,
  input  logic                 dead_char,
  input  logic [NUM_SLOTS-1:0] slot_ready,
  output logic [NUM_SLOTS-1:0] fire,
  output logic [IW-1:0]        fire_idx,
  output logic                 cooldown_active,
  output logic [15:0]          launch_count
);

  localparam logic [4:0] MAX_LIVE_C = 5'(MAX_LIVE);
  localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN_FRAMES);

  logic [NUM_SLOTS-1:0] fire_r;
  logic [IW-1:0]        fire_idx_r;
  logic [IW-1:0]        rr_ptr_r;
  logic [7:0]           cooldown_r;
  logic [15:0]          launch_count_r;
  logic                 armed_r;

  logic                 key_down_s;
  logic [15:0]          busy_s;
  logic [4:0]           live_s;
  logic                 pick_valid_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 launch_s;
  logic [NUM_SLOTS-1:0] fire_next_s;
  logic [IW-1:0]        rr_next_s;

  slot_picker #(
    .NUM_SLOTS (NUM_SLOTS),
    .ALLOC_MODE(ALLOC_MODE)
  ) u_picker (
    .req  (slot_ready),
    .start(rr_ptr_r),
    .valid(pick_valid_s),
    .index(pick_idx_s)
  );

  // Launch qualification and next-value computation.
  always_comb begin
    key_down_s = (keycode == FIRE_KEY) && press;
    busy_s = 16'd0;
    busy_s[NUM_SLOTS-1:0] = ~slot_ready;
    live_s = popcount(busy_s);
    launch_s = frame_clk_edge && key_down_s && armed_r && !dead_char &&
               (cooldown_r == 8'd0) && (live_s < MAX_LIVE_C) && pick_valid_s;
    fire_next_s = launch_s ? (NUM_SLOTS'(1'b1) << pick_idx_s) : {NUM_SLOTS{1'b0}};
    rr_next_s = (pick_idx_s == IW'(NUM_SLOTS - 1)) ? {IW{1'b0}} : (pick_idx_s + IW'(1'b1));
  end

  // Launcher state; everything except the strobe only moves on frame edges.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fire_r         <= {NUM_SLOTS{1'b0}};
      fire_idx_r     <= {IW{1'b0}};
      rr_ptr_r       <= {IW{1'b0}};
      cooldown_r     <= 8'd0;
      launch_count_r <= 16'd0;
      armed_r        <= 1'b1;
    end else begin
      fire_r <= fire_next_s;
      if (frame_clk_edge) begin
        if (launch_s) begin
          fire_idx_r     <= pick_idx_s;
          armed_r        <= 1'b0;
          cooldown_r     <= COOLDOWN_C;
          launch_count_r <= launch_count_r + 16'd1;
          if (ALLOC_MODE == ALLOC_RR) begin
            rr_ptr_r <= rr_next_s;
          end
        end else begin
          // Refused launches leave armed alone so a held press fires later.
          if (!key_down_s) begin
            armed_r <= 1'b1;
          end
          if (cooldown_r != 8'd0) begin
            cooldown_r <= cooldown_r - 8'd1;
          end
        end
      end
    end
  end

  assign fire            = fire_r;
  assign fire_idx        = fire_idx_r;
  assign cooldown_active = (cooldown_r != 8'd0);
  assign launch_count    = launch_count_r;

endmodule

// File: tb/tb_projectile_launcher.sv
// Scoreboard bench: two launcher configurations share random stimulus and are
// checked against a behavioural model of the launch rules.
module tb_projectile_launcher;
  import projectile_pkg::*;

  localparam logic [7:0] K = 8'h29;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk_edge = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       press = 1'b0;
  logic       dead_char = 1'b0;
  logic [4:0] slot_ready = 5'b11111;

  logic [4:0]  fire_w [2];
  logic [2:0]  idx_w  [2];
  logic        ca_w   [2];
  logic [15:0] cnt_w  [2];

  int checks = 0;
  int errors = 0;

  // model configuration and state per instance
  int p_mode [2] = '{0, 1};
  int p_cd   [2] = '{8, 0};
  int p_max  [2] = '{5, 2};
  int m_armed [2] = '{1, 1};
  int m_cd    [2] = '{0, 0};
  int m_rr    [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int m_idx   [2] = '{0, 0};
  int exp_q [2][$];

  always #5 Clk = ~Clk;

  projectile_launcher #(.NUM_SLOTS(5), .FIRE_KEY(8'h29), .COOLDOWN_FRAMES(8),
                        .ALLOC_MODE(ALLOC_LOWEST), .MAX_LIVE(5)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk_edge(frame_clk_edge), .keycode(keycode),
    .press(press), .dead_char(dead_char), .slot_ready(slot_ready), .fire(fire_w[0]),
    .fire_idx(idx_w[0]), .cooldown_active(ca_w[0]), .launch_count(cnt_w[0]));

  projectile_launcher #(.NUM_SLOTS(5), .FIRE_KEY(8'h29), .COOLDOWN_FRAMES(0),
                        .ALLOC_MODE(ALLOC_RR), .MAX_LIVE(2)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk_edge(frame_clk_edge), .keycode(keycode),
    .press(press), .dead_char(dead_char), .slot_ready(slot_ready), .fire(fire_w[1]),
    .fire_idx(idx_w[1]), .cooldown_active(ca_w[1]), .launch_count(cnt_w[1]));

  task automatic chk(input string name, input int k, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0d required %0d", name, k, $time, got, expv);
    end
  endtask

  // Behavioural model: what the upcoming clock edge must do with current inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!Reset_n) begin
        m_armed[k] = 1; m_cd[k] = 0; m_rr[k] = 0; m_cnt[k] = 0; m_idx[k] = 0;
      end else if (frame_clk_edge) begin
        int  live;
        int  sel;
        bit  key_down;
        key_down = (keycode == K) && press;
        live = 0;
        for (int i = 0; i < 5; i++) if (!slot_ready[i]) live++;
        sel = -1;
        for (int i = 0; i < 5; i++) begin
          int pos;
          pos = (p_mode[k] == 1) ? (m_rr[k] + i) % 5 : i;
          if (sel < 0 && slot_ready[pos]) sel = pos;
        end
        if (key_down && m_armed[k] == 1 && !dead_char && m_cd[k] == 0 &&
            live < p_max[k] && sel >= 0) begin
          exp_q[k].push_back(sel);
          m_armed[k] = 0;
          m_cd[k] = p_cd[k];
          m_cnt[k] = (m_cnt[k] + 1) % 65536;
          m_idx[k] = sel;
          if (p_mode[k] == 1) m_rr[k] = (sel + 1) % 5;
        end else begin
          if (!key_down) m_armed[k] = 1;
          if (m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic fe, input logic [7:0] kc,
                       input logic pr, input logic dd, input logic [4:0] rd);
    @(negedge Clk);
    #1;
    Reset_n = rst; frame_clk_edge = fe; keycode = kc; press = pr;
    dead_char = dd; slot_ready = rd;
    model_step();
  endtask

  // One frame edge followed by two cycles of junk that must be ignored.
  task automatic frame(input logic [7:0] kc, input logic pr, input logic dd, input logic [4:0] rd);
    drive(1'b1, 1'b1, kc, pr, dd, rd);
    for (int g = 0; g < 2; g++)
      drive(1'b1, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
  endtask

  // Monitor: pops the scoreboard whenever a strobe is due or seen.
  initial begin
    forever begin
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        if (fire_w[k] != 5'd0) begin
          if (exp_q[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fire inst%0d at %0t: got %b required 00000", k, $time, fire_w[k]);
          end else begin
            int e;
            logic [4:0] ef;
            e = exp_q[k].pop_front();
            ef = 5'b00001 << e;
            chk("fire_onehot", k, int'(fire_w[k]), int'(ef));
          end
        end else if (exp_q[k].size() != 0) begin
          int e;
          e = exp_q[k].pop_front();
          checks++; errors++;
          $display("FAIL missing_fire inst%0d at %0t: got 00000 required slot %0d", k, $time, e);
        end
        chk("fire_idx", k, int'(idx_w[k]), m_idx[k]);
        chk("cooldown_active", k, int'(ca_w[k]), (m_cd[k] != 0) ? 1 : 0);
        chk("launch_count", k, int'(cnt_w[k]), m_cnt[k]);
      end
    end
  end

  initial begin
    // reset, then first launch on slot 0
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    drive(1'b0, 1'b1, K, 1'b1, 1'b0, 5'b11111);
    frame(K, 1'b1, 1'b0, 5'b11111);
    // held key: exactly one launch, then release and re-press
    for (int i = 0; i < 20; i++) frame(K, 1'b1, 1'b0, 5'b11110);
    frame(K, 1'b0, 1'b0, 5'b11110);
    frame(K, 1'b1, 1'b0, 5'b11110);
    frame(K, 1'b0, 1'b0, 5'b11111);
    // round-robin sequence from reset
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    for (int i = 0; i < 6; i++) begin
      frame(K, 1'b1, 1'b0, 5'b11111);
      frame(K, 1'b0, 1'b0, 5'b11111);
    end
    // press held through the cooldown
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    frame(K, 1'b1, 1'b0, 5'b11111);
    for (int i = 0; i < 2; i++) frame(K, 1'b0, 1'b0, 5'b11111);
    for (int i = 0; i < 10; i++) frame(K, 1'b1, 1'b0, 5'b11111);
    // live-projectile limit
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    for (int i = 0; i < 2; i++) frame(K, 1'b1, 1'b0, 5'b11100);
    for (int i = 0; i < 2; i++) frame(K, 1'b1, 1'b0, 5'b11110);
    // dead character, then reset mid-cooldown
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    for (int i = 0; i < 3; i++) frame(K, 1'b1, 1'b1, 5'b11111);
    frame(K, 1'b0, 1'b1, 5'b11111);
    frame(K, 1'b1, 1'b0, 5'b11111);
    frame(K, 1'b0, 1'b0, 5'b11111);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    frame(K, 1'b1, 1'b0, 5'b11111);
    frame(8'h30, 1'b1, 1'b0, 5'b11111);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0)
        drive(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 5'($urandom));
      else
        frame(($urandom_range(0, 3) == 0) ? 8'($urandom) : K, 1'($urandom),
              ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 5'($urandom));
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'b11111);
    @(negedge Clk);
    #2;
    for (int k = 0; k < 2; k++) chk("queue_drained", k, exp_q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
